// File: rtl/int_arbiter_pkg.sv
// int_arbiter_pkg: register map, bus constants and gateway state encoding for the external interrupt controller
package int_arbiter_pkg;

    localparam logic [31:0] INTC_BASE      = 32'h1000_2000;
    localparam int          INT_EXT        = 11;
    localparam logic [7:0]  INTC_PENDING   = 8'h00;
    localparam logic [7:0]  INTC_ENABLE    = 8'h04;
    localparam logic [7:0]  INTC_THRESH    = 8'h08;
    localparam logic [7:0]  INTC_CLAIM     = 8'h0C;
    localparam logic [7:0]  INTC_PRIO_BASE = 8'h10;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_IN_SERVICE
    } gw_state_e;

    function automatic logic [7:0] prio_off(input int id);
        return INTC_PRIO_BASE + 8'(4 * (id - 1));
    endfunction

endpackage

// File: rtl/int_arbiter_gateway.sv
// int_arbiter_gateway: per-source synchroniser, rising-edge detect and claim/complete state machine
module int_gateway
    import int_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending
);

    logic [2:0] sync_q;
    logic       src_edge;
    logic       repend_q, repend_d;
    gw_state_e  state_q, state_d;

    assign src_edge = sync_q[1] & ~sync_q[2];
    assign pending  = state_q == GW_PENDING;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= GW_IDLE;
            repend_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], src};
            state_q  <= state_d;
            repend_q <= repend_d;
        end
    end

    // an edge arriving in the same cycle as complete re-arms the source directly
    always_comb begin
        state_d  = state_q;
        repend_d = repend_q;
        case (state_q)
            GW_IDLE:       state_d = src_edge ? GW_PENDING : GW_IDLE;
            GW_PENDING:    state_d = claim_hit ? GW_IN_SERVICE : GW_PENDING;
            GW_IN_SERVICE: begin
                if (complete_hit) begin
                    state_d  = (repend_q | src_edge) ? GW_PENDING : GW_IDLE;
                    repend_d = 1'b0;
                end else if (src_edge) begin
                    repend_d = 1'b1;
                end
            end
            default:       state_d = GW_IDLE;
        endcase
    end

endmodule

// File: rtl/int_arbiter.sv
// int_arbiter: platform external interrupt controller with per-source enable/priority,
// global threshold and memory-mapped claim/complete
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               wr_en_i,
    input  logic [31:0]        wr_addr_i,
    input  logic [31:0]        wr_data_i,
    input  logic               rd_en_i,
    input  logic [31:0]        rd_addr_i,
    output logic [31:0]        rd_data_o,
    output logic               int_req_o,
    output logic [4:0]         claim_id_o
);

    logic [7:0]         wa, ra;
    logic               claim, complete;
    logic [NUM_SRC-1:0] enable_q, pending, claim_hit, complete_hit;
    logic [PRIO_W-1:0]  thresh_q, win_prio;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [4:0]         best_id, win_id;
    logic               unused;

    assign wa         = wr_addr_i[7:0];
    assign ra         = rd_addr_i[7:0];
    assign claim      = rd_en_i && ra == INTC_CLAIM;
    assign complete   = wr_en_i && wa == INTC_CLAIM;
    assign claim_id_o = best_id;
    assign unused     = ^{wr_addr_i[31:8], rd_addr_i[31:8]};

    for (genvar g = 0; g < NUM_SRC; g++) begin : gw
        assign claim_hit[g]    = claim && best_id == 5'(g + 1);
        assign complete_hit[g] = complete && wr_data_i == 32'(g + 1);
        int_gateway u_gw (
            .clk          (clk),
            .rst_n        (rst_n),
            .src          (src_i[g]),
            .claim_hit    (claim_hit[g]),
            .complete_hit (complete_hit[g]),
            .pending      (pending[g])
        );
    end

    // the source being claimed this cycle is masked so the next winner registers immediately
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int k = 0; k < NUM_SRC; k++)
            if (pending[k] && enable_q[k] && !claim_hit[k] &&
                prio_q[k] > thresh_q && prio_q[k] > win_prio) begin
                win_id   = 5'(k + 1);
                win_prio = prio_q[k];
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= '0;
            thresh_q  <= '0;
            best_id   <= '0;
            int_req_o <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) prio_q[k] <= '0;
        end else begin
            if (wr_en_i && wa == INTC_ENABLE) enable_q <= wr_data_i[NUM_SRC-1:0];
            if (wr_en_i && wa == INTC_THRESH) thresh_q <= wr_data_i[PRIO_W-1:0];
            for (int k = 0; k < NUM_SRC; k++)
                if (wr_en_i && wa == prio_off(k + 1)) prio_q[k] <= wr_data_i[PRIO_W-1:0];
            best_id   <= win_id;
            int_req_o <= win_id != '0;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (ra)
            INTC_PENDING: rd_data_o = 32'(pending);
            INTC_ENABLE:  rd_data_o = 32'(enable_q);
            INTC_THRESH:  rd_data_o = 32'(thresh_q);
            INTC_CLAIM:   rd_data_o = 32'(best_id);
            default:      ;
        endcase
        for (int k = 0; k < NUM_SRC; k++)
            if (ra == prio_off(k + 1)) rd_data_o = 32'(prio_q[k]);
    end

endmodule
